// File: rtl/display_scheduler_pkg.sv
// Shared types and sizing for the display scheduler and its double-dabble engine.
package display_scheduler_pkg;

  localparam int DATA_W   = 32;
  localparam int DIGITS   = 10;
  localparam int BCD_W    = 4 * DIGITS;
  localparam int HOLD_CYC = 2 ** 24;
  localparam int CNT_W    = $clog2(DATA_W + 1);

  // Widest binary input whose maximum value still fits in DIGITS decimal digits.
  localparam int MAX_BIN_BITS = $rtoi(DIGITS * 3.321928094887362);

  localparam logic [3:0] MODE_DASH = 4'ha;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/display_scheduler_if.sv
// Requester handshakes, clear input and seven-segment driver outputs of the display scheduler.
interface display_scheduler_if;
  import display_scheduler_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [3:0]        req0_mode;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [3:0]        req1_mode;
  logic              clear;
  logic [BCD_W-1:0]  BCD;
  logic [3:0]        mode;
  logic              en;
  logic              busy;

  modport master (
    output req0_valid, req0_data, req0_mode,
    output req1_valid, req1_data, req1_mode,
    output clear,
    input  req0_ready, req1_ready, BCD, mode, en, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_mode,
    input  req1_valid, req1_data, req1_mode,
    input  clear,
    output req0_ready, req1_ready, BCD, mode, en, busy
  );

endinterface

// File: rtl/display_scheduler_bin2bcd.sv
// Iterative double-dabble converter: one add-3/shift step per clock, DATA_W steps per value.
module bin2bcd_seq
  import display_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]  acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;

  // done flags the cycle whose clock edge performs the final iteration
  assign done = active_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign bcd  = acc_q;

  always_comb begin
    acc_adj  = acc_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    if (start) begin
      shift_d  = bin;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d   = {acc_adj[BCD_W-2:0], shift_q[DATA_W-1]};
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin arbiter, conversion FSM and registered driver outputs for the 12-digit display.
// Optional DISPLAY_HOLD_EN keeps each shown value up for HOLD_CYC cycles before the next grant.
module display_scheduler
  import display_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  display_scheduler_if.slave  bus
);

  if (DATA_W > MAX_BIN_BITS) begin : g_width_check
    $error("DATA_W exceeds what DIGITS decimal digits can represent");
  end

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       mode_hold_q, mode_hold_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       mode_q, mode_d;
  logic             en_q, en_d;

  logic             grant0, grant1, rdy0, rdy1, accept, hold_ok;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

`ifdef DISPLAY_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign hold_ok = (hold_q == '0);

  always_comb begin
    hold_d = hold_q;
    if (state_q == DONE) begin
      hold_d = HOLD_W'(HOLD_CYC);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_ok = 1'b1;
`endif

  // With both requesters valid the pointer side wins; a lone requester always wins.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || ptr_q);
  assign rdy0   = !rst && (state_q == IDLE) && hold_ok && grant0;
  assign rdy1   = !rst && (state_q == IDLE) && hold_ok && grant1;
  assign accept = rdy0 || rdy1;

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.BCD        = bcd_q;
  assign bus.mode       = mode_q;
  assign bus.en         = en_q;
  assign bus.busy       = (state_q != IDLE);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (rdy0 ? bus.req0_data : bus.req1_data),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mode_hold_d = mode_hold_q;
    bcd_d       = bcd_q;
    mode_d      = mode_q;
    en_d        = en_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = CONV;
          mode_hold_d = rdy0 ? bus.req0_mode : bus.req1_mode;
          ptr_d       = rdy0;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = conv_bcd;
        mode_d  = mode_hold_q;
        en_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      mode_hold_q <= '0;
      bcd_q       <= '0;
      mode_q      <= '0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mode_hold_q <= mode_hold_d;
      bcd_q       <= bcd_d;
      mode_q      <= mode_d;
      en_q        <= en_d;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler: reset, conversion, arbitration, clear and reset recovery.
module tb_display_scheduler;
  import display_scheduler_pkg::*;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  display_scheduler_if bus ();

  display_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raises valid on one side at a negedge, waits (bounded) for ready, lets the
  // handshake edge pass and drops valid at the following negedge.
  task automatic applyStimulus(input bit side, input logic [31:0] data,
                               input logic [3:0] m, output int waited);
    bit rdy;
    waited = 0;
    if (side) begin
      bus.req1_data = data; bus.req1_mode = m; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_data = data; bus.req0_mode = m; bus.req0_valid = 1'b1;
    end
    #1;
    rdy = side ? bus.req1_ready : bus.req0_ready;
    while (!rdy && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
      rdy = side ? bus.req1_ready : bus.req0_ready;
    end
    if (!rdy) begin
      waited = -1;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.clear = 1'b0;
    bus.req0_data = '0; bus.req0_mode = '0; bus.req1_data = '0; bus.req1_mode = '0;
    @(negedge clk);
    testsRun++;
    if (bus.BCD !== 40'h0 || bus.mode !== 4'h0 || bus.en !== 1'b0 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: BCD=%h mode=%h en=%b busy=%b, required all zero",
               bus.BCD, bus.mode, bus.en, bus.busy);
    end
    bus.req0_valid = 1'b1;
    #1;
    testsRun++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: ready0=%b ready1=%b, required 0 0", bus.req0_ready, bus.req1_ready);
    end
    rst = 1'b0;
    #1;
    testsRun++;
    if (bus.req0_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL release_ready: ready0=%b, required 1", bus.req0_ready);
    end
    bus.req0_valid = 1'b0;
    #1;
    testsRun++;
    if (bus.req0_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL drop_valid_ready: ready0=%b, required 0", bus.req0_ready);
    end
    @(negedge clk);
    testsRun++;
    if (bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL drop_valid_busy: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_single;
    int w;
    applyStimulus(1'b0, 32'd1234567890, 4'h3, w);
    testsRun++;
    if (w < 0 || bus.busy !== 1'b1 || bus.req0_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_accept: waited=%0d busy=%b ready0=%b, required >=0 1 0", w, bus.busy, bus.req0_ready);
    end
    repeat (32) @(negedge clk);
    testsRun++;
    if (bus.busy !== 1'b1 || bus.en !== 1'b0 || bus.BCD !== 40'h0) begin
      testsFailed++;
      $display("[TB] FAIL single_edge32: busy=%b en=%b BCD=%h, required 1 0 0", bus.busy, bus.en, bus.BCD);
    end
    @(negedge clk);
    testsRun++;
    if (bus.BCD !== 40'h1234567890 || bus.mode !== 4'h3 || bus.en !== 1'b1 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_result: BCD=%h mode=%h en=%b busy=%b, required 1234567890 3 1 0",
               bus.BCD, bus.mode, bus.en, bus.busy);
    end
  endtask

  task automatic test_extremes;
    int w;
    applyStimulus(1'b1, 32'hFFFFFFFF, MODE_DASH, w);
    repeat (33) @(negedge clk);
    testsRun++;
    if (w < 0 || bus.BCD !== 40'h4294967295 || bus.mode !== MODE_DASH || bus.en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL max_value: waited=%0d BCD=%h mode=%h en=%b, required 4294967295 a 1",
               w, bus.BCD, bus.mode, bus.en);
    end
    applyStimulus(1'b0, 32'd0, 4'h1, w);
    repeat (33) @(negedge clk);
    testsRun++;
    if (w < 0 || bus.BCD !== 40'h0 || bus.mode !== 4'h1 || bus.en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL zero_value: waited=%0d BCD=%h mode=%h en=%b, required 0 1 1",
               w, bus.BCD, bus.mode, bus.en);
    end
  endtask

  task automatic test_round_robin;
    logic [39:0] expBcd;
    rst = 1'b1;
    bus.req0_data = 32'd5; bus.req0_mode = 4'h0; bus.req0_valid = 1'b1;
    bus.req1_data = 32'd7; bus.req1_mode = 4'h1; bus.req1_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int r = 0; r < 3; r++) begin
      testsRun++;
      if (bus.req0_ready !== (r % 2 == 0) || bus.req1_ready !== (r % 2 == 1)) begin
        testsFailed++;
        $display("[TB] FAIL rr_grant%0d: ready0=%b ready1=%b, required %0d %0d",
                 r, bus.req0_ready, bus.req1_ready, (r % 2 == 0), (r % 2 == 1));
      end
      repeat (34) @(negedge clk);
      expBcd = (r % 2 == 0) ? 40'h5 : 40'h7;
      testsRun++;
      if (bus.BCD !== expBcd || bus.mode !== 4'(r % 2) || bus.en !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL rr_result%0d: BCD=%h mode=%h en=%b, required %h %0d 1",
                 r, bus.BCD, bus.mode, bus.en, expBcd, r % 2);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_clear;
    int w;
    @(negedge clk);
    applyStimulus(1'b0, 32'd42, 4'h2, w);
    repeat (9) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    testsRun++;
    if (bus.en !== 1'b0 || bus.busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL clear_mid_conv: en=%b busy=%b, required 0 1", bus.en, bus.busy);
    end
    bus.clear = 1'b0;
    repeat (23) @(negedge clk);
    testsRun++;
    if (w < 0 || bus.en !== 1'b1 || bus.BCD !== 40'h42 || bus.mode !== 4'h2) begin
      testsFailed++;
      $display("[TB] FAIL clear_then_done: waited=%0d en=%b BCD=%h mode=%h, required 1 42 2",
               w, bus.en, bus.BCD, bus.mode);
    end
    applyStimulus(1'b1, 32'd99, 4'h5, w);
    repeat (32) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    testsRun++;
    if (w < 0 || bus.en !== 1'b0 || bus.BCD !== 40'h99 || bus.mode !== 4'h5) begin
      testsFailed++;
      $display("[TB] FAIL clear_at_done: waited=%0d en=%b BCD=%h mode=%h, required 0 99 5",
               w, bus.en, bus.BCD, bus.mode);
    end
  endtask

  task automatic test_reset_mid;
    int w;
    applyStimulus(1'b0, 32'd1234, 4'h7, w);
    repeat (9) @(negedge clk);
    bus.req1_data = 32'd987654321; bus.req1_mode = 4'h4; bus.req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    testsRun++;
    if (bus.BCD !== 40'h0 || bus.mode !== 4'h0 || bus.en !== 1'b0 || bus.busy !== 1'b0 || bus.req1_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_outputs: BCD=%h mode=%h en=%b busy=%b ready1=%b, required all zero",
               bus.BCD, bus.mode, bus.en, bus.busy, bus.req1_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'd987654321, 4'h4, w);
    testsRun++;
    if (w !== 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_accept: waited=%0d cycles, required 0", w);
    end
    repeat (33) @(negedge clk);
    testsRun++;
    if (bus.BCD !== 40'h0987654321 || bus.mode !== 4'h4 || bus.en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_result: BCD=%h mode=%h en=%b, required 0987654321 4 1",
               bus.BCD, bus.mode, bus.en);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    applyStimulus(1'b0, 32'd11, 4'h1, w);
    repeat (33) @(negedge clk);
    testsRun++;
    if (w < 0 || bus.BCD !== 40'h11 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: waited=%0d BCD=%h busy=%b, required 11 0", w, bus.BCD, bus.busy);
    end
    applyStimulus(1'b1, 32'd22, 4'h2, w);
    testsRun++;
    if (w !== 0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_immediate_grant: waited=%0d cycles, required 0", w);
    end
    repeat (33) @(negedge clk);
    testsRun++;
    if (bus.BCD !== 40'h22 || bus.mode !== 4'h2 || bus.en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: BCD=%h mode=%h en=%b, required 22 2 1", bus.BCD, bus.mode, bus.en);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequencing controller in front of the 12-digit seven-segment driver.
- Arbitrates between two result producers (e.g. key/message path and cipher-result path) that each present a 32-bit binary value plus a 4-bit mode character.
- Converts the granted value to 10 BCD digits with an iterative double-dabble engine.
- Drives the driver's `BCD[39:0]`, `mode[3:0]` and `en` from registers, so the display never shows a half-converted value.

Parameters:
- DATA_W, 32, binary input width; one conversion iteration per bit.
- DIGITS, 10, BCD output digits; BCD width = 4*DIGITS.
- HOLD_CYC, 2**24, minimum cycles a shown value is held before the next grant (used only with DISPLAY_HOLD_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a value
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req0_data  in  DATA_W  requester 0 binary value
- req0_mode  in  4  requester 0 mode character
- req1_valid  in  1  requester 1 has a value
- req1_ready  out  1  requester 1 handshake accepted this cycle
- req1_data  in  DATA_W  requester 1 binary value
- req1_mode  in  4  requester 1 mode character
- clear  in  1  blank numeric digits (display shows dashes and mode only)
- BCD  out  4*DIGITS  packed digits to driver; digit 0 in [3:0]
- mode  out  4  mode character to driver
- en  out  1  numeric-digit enable to driver
- busy  out  1  conversion in progress

Behaviour:
- Reset (async, rst=1): BCD=0, mode=0, en=0, req*_ready=0, busy=0, state=IDLE, round-robin pointer=0 (requester 0 has priority), hold counter=0.
- All state updates occur on posedge clk.
- FSM IDLE:
  - `ready` is combinational.
  - `reqN_ready` = IDLE & reqN_valid & grant(N). Requesters must hold data and mode stable while valid.
  - Grant: if exactly one requester is valid, grant it. If both are valid, grant the pointer side.
  - On a handshake edge: capture data into the shift register, mode into mode_hold, clear the BCD accumulator, iteration count=0, flip pointer to the other requester, go to CONV.
- FSM CONV:
  - Each edge: for every digit ≥5 add 3, then shift {acc,shift} left by 1; count+1.
  - After DATA_W edges, go to DONE.
  - busy=1 in CONV and DONE.
- FSM DONE:
  - One edge: BCD<=acc, mode<=mode_hold, en<=1 (unless clear is high this cycle), go to IDLE.
- Latency: outputs change at edge DATA_W+1 after the handshake edge (33 for default).
  - Earliest next handshake is the cycle after DONE.
  - Throughput: one value per DATA_W+2 cycles.
- clear:
  - In any state, en<=0 on that edge. BCD and mode are unaffected.
  - Clear asserted during CONV does not abort; the following DONE still sets en=1.
  - Clear coincident with DONE: BCD and mode update, en stays 0.
- Overflow:
  - Any value ≥10^DIGITS cannot fit. With default widths it is impossible (2^32−1 < 10^10).
  - Elaboration must fail if DATA_W > floor(DIGITS*log2(10)).
- rst mid-operation: conversion discarded, all outputs to reset values; a still-valid requester is accepted in the first IDLE cycle after reset release.
- Valid dropped without a handshake: no effect and no state change.

Optional Feature:
- DISPLAY_HOLD_EN defined:
  - Hold counter loads HOLD_CYC at DONE and decrements each cycle.
  - IDLE grants nothing while counter≠0; clear does not reset the counter.
- DISPLAY_HOLD_EN undefined:
  - No counter, HOLD_CYC unused; grants are possible immediately after DONE.

Decomposition:
- Shared package: state encoding (IDLE, CONV, DONE), DATA_W/DIGITS defaults, BCD_W = 4*DIGITS, mode constant for dash (4'ha).
- One sub-module: bin2bcd_seq, the double-dabble engine.
  - Ports: clk, rst, start, bin, done, bcd.
  - Owns shift register and iteration counter.
- display_scheduler keeps arbitration, FSM, output registers and hold logic.

Test Plan:
- Reset check: assert rst → BCD=0, mode=0, en=0, busy=0, both ready=0. Release rst → ready follows valid/grant in the same cycle.
- Single request: req0 data=32'd1234567890, mode=4'h3 → req0_ready 1 cycle; 33 edges later BCD=40'h1234567890, mode=4'h3, en=1; busy high 33 cycles.
- Conversion extremes: data=32'hFFFFFFFF → BCD=40'h4294967295. Data=0 → BCD=0, en=1.
- Round-robin arbitration: both valid from reset (req0=5, req1=7, held) → grants alternate 0,1,0,… with BCD sequence 5,7,5; neither requester starves.
- clear timing: clear pulse coincident with DONE edge → BCD updated, en=0. Clear mid-CONV → en=0 next edge, en=1 at DONE.
- Reset mid-operation: rst at iteration 10 → outputs reset immediately. req1 still valid → accepted first IDLE cycle after release, correct result 33 edges later.
